// File: rtl/wash_pkg.sv
// Shared types and the program timing table for the wash program sequencer.
package wash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RUN_FILL  = 3'd1,
    ST_RUN_WASH  = 3'd2,
    ST_RUN_DRAIN = 3'd3,
    ST_RUN_SPIN  = 3'd4,
    ST_FAULT     = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    PROG_QUICK  = 2'd0,
    PROG_NORMAL = 2'd1,
    PROG_HEAVY  = 2'd2
  } prog_t;

  typedef enum logic [1:0] {
    PH_WASH  = 2'd0,
    PH_RINSE = 2'd1,
    PH_SPIN  = 2'd2
  } phase_t;

  // Fault codes; the watchdog kind register reuses the fill/drain codes.
  localparam logic [1:0] FC_NONE  = 2'd0;
  localparam logic [1:0] FC_FILL  = 2'd1;
  localparam logic [1:0] FC_DRAIN = 2'd2;
  localparam logic [1:0] FC_DOOR  = 2'd3;

  // Selector value 3 is not a program of its own and runs as normal.
  function automatic prog_t decode_prog(input logic [1:0] sel);
    prog_t p;
    case (sel)
      2'd0:    p = PROG_QUICK;
      2'd2:    p = PROG_HEAVY;
      default: p = PROG_NORMAL;
    endcase
    return p;
  endfunction

  // Phase duration in seconds for each program.
  function automatic logic [7:0] phase_secs(input prog_t prog, input phase_t ph);
    logic [7:0] secs;
    secs = 8'd0;
    case (prog)
      PROG_QUICK: begin
        case (ph)
          PH_WASH:  secs = 8'd5;
          PH_RINSE: secs = 8'd3;
          default:  secs = 8'd2;
        endcase
      end
      PROG_HEAVY: begin
        case (ph)
          PH_WASH:  secs = 8'd20;
          PH_RINSE: secs = 8'd8;
          default:  secs = 8'd6;
        endcase
      end
      default: begin
        case (ph)
          PH_WASH:  secs = 8'd10;
          PH_RINSE: secs = 8'd5;
          default:  secs = 8'd4;
        endcase
      end
    endcase
    return secs;
  endfunction

endpackage

// File: rtl/wash_program_sequencer_sec_timer.sv
// Seconds timer: a prescaler producing one tick per TICK_DIV clocks feeding an
// 8-bit down-counter. Load restarts both from zero; expired holds once the
// count reaches zero and stays until the next load or clear.
module sec_timer #(
  parameter int TICK_DIV = 100
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic       clear,
  input  logic [7:0] load_secs,
  output logic       tick,
  output logic       expired,
  output logic [7:0] secs
);

  localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q;
  logic [7:0]    secs_q;
  logic          armed_q;

  assign tick    = armed_q && (secs_q != 8'd0) && (presc_q == PRESC_LAST);
  assign expired = armed_q && (secs_q == 8'd0);
  assign secs    = secs_q;

  // Prescaler and down-counter; counting stops at terminal count zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      secs_q  <= 8'd0;
      armed_q <= 1'b0;
    end else if (clear) begin
      presc_q <= '0;
      secs_q  <= 8'd0;
      armed_q <= 1'b0;
    end else if (load) begin
      presc_q <= '0;
      secs_q  <= load_secs;
      armed_q <= 1'b1;
    end else if (armed_q && (secs_q != 8'd0)) begin
      if (tick) begin
        presc_q <= '0;
        secs_q  <= secs_q - 8'd1;
      end else begin
        presc_q <= presc_q + PW'(1);
      end
    end
  end

endmodule

// File: rtl/wash_program_sequencer.sv
// Program controller in front of the washer FSM: gates the user start, times
// wash/rinse/spin per program, watches fill/drain and the door, holds faults.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | waiting for a start rising edge with the door closed
// ST_RUN_FILL  | washer filling (also the entry state of every program)
// ST_RUN_WASH  | washer agitating; wash or rinse duration timed
// ST_RUN_DRAIN | washer draining without motor
// ST_RUN_SPIN  | washer spinning; spin duration timed
// ST_FAULT     | sticky fault; leaves when start=0 and door closed together
//
// The state register is the once-registered phase decode: a new washer phase
// is sampled straight into the state, so timers start on that same edge.
// When several status patterns coincide the decode prefers spin, then wash,
// then fill, then drain.
module wash_program_sequencer
  import wash_pkg::*;
#(
  parameter int TICK_DIV    = 100,
  parameter int FILL_LIMIT  = 30,
  parameter int DRAIN_LIMIT = 20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] prog_sel,
  input  logic       start,
  input  logic       door_close,
  input  logic       motor_on,
  input  logic       fill_value_on,
  input  logic       drain_value_on,
  input  logic       soap_wash,
  input  logic       water_wash,
  input  logic       done,
  output logic       start_out,
  output logic       cycle_timeout,
  output logic       spin_timeout,
  output logic       busy,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [7:0] secs_left
);

  state_t     state_q, state_d;
  prog_t      prog_q, prog_d;
  logic       start_q;
  logic [1:0] fault_code_q, fault_code_d;
  logic [1:0] wd_kind_q, wd_kind_d;

  logic       dec_wash, dec_spin, dec_fill, dec_drain;
  logic       start_rise, run_q, run_d, timed_d;
  logic       ph_load, ph_clear, ph_expired, ph_tick_unused;
  logic [7:0] ph_load_secs, ph_secs;
  logic       wd_load, wd_clear, wd_tick, wd_expired_unused, wd_fire;
  logic [7:0] wd_load_secs, wd_secs;

  assign dec_wash   = motor_on & ~drain_value_on;
  assign dec_spin   = motor_on & drain_value_on;
  assign dec_fill   = fill_value_on;
  assign dec_drain  = drain_value_on & ~motor_on;
  assign start_rise = start & ~start_q;

  assign run_q   = state_q inside {ST_RUN_FILL, ST_RUN_WASH, ST_RUN_DRAIN, ST_RUN_SPIN};
  assign run_d   = state_d inside {ST_RUN_FILL, ST_RUN_WASH, ST_RUN_DRAIN, ST_RUN_SPIN};
  assign timed_d = state_d inside {ST_RUN_WASH, ST_RUN_SPIN};

  // The watchdog faults on the edge its last second completes, so the fault
  // lands exactly LIMIT seconds after the condition was first sampled.
  assign wd_fire = (wd_kind_q != FC_NONE) && wd_tick && (wd_secs == 8'd1);

  // Next-state decision in priority order: door, watchdog, done, phase.
  always_comb begin
    state_d      = state_q;
    prog_d       = prog_q;
    fault_code_d = fault_code_q;
    case (state_q)
      ST_IDLE: begin
        if (start_rise && door_close) begin
          state_d = ST_RUN_FILL;
          prog_d  = decode_prog(prog_sel);
        end
      end
      ST_FAULT: begin
        if (!start && door_close) begin
          state_d      = ST_IDLE;
          fault_code_d = FC_NONE;
        end
      end
      default: begin
        if (!door_close) begin
          state_d      = ST_FAULT;
          fault_code_d = FC_DOOR;
        end else if (wd_fire) begin
          state_d      = ST_FAULT;
          fault_code_d = wd_kind_q;
        end else if (done) begin
          state_d = ST_IDLE;
        end else if (dec_spin) begin
          state_d = ST_RUN_SPIN;
        end else if (dec_wash) begin
          state_d = ST_RUN_WASH;
        end else if (dec_fill) begin
          state_d = ST_RUN_FILL;
        end else if (dec_drain) begin
          state_d = ST_RUN_DRAIN;
        end
      end
    endcase
  end

  // Phase timer restarts on entry to a timed phase and clears outside one.
  always_comb begin
    ph_load  = timed_d && (state_d != state_q);
    ph_clear = !timed_d;
    if (state_d == ST_RUN_SPIN) begin
      ph_load_secs = phase_secs(prog_q, PH_SPIN);
    end else if (water_wash && !soap_wash) begin
      ph_load_secs = phase_secs(prog_q, PH_RINSE);
    end else begin
      ph_load_secs = phase_secs(prog_q, PH_WASH);
    end
  end

  // Watchdog tracks which condition is running and restarts when it changes.
  always_comb begin
    wd_kind_d = FC_NONE;
    if (run_d && dec_fill) begin
      wd_kind_d = FC_FILL;
    end else if (run_d && dec_drain) begin
      wd_kind_d = FC_DRAIN;
    end
    wd_load      = (wd_kind_d != FC_NONE) && (wd_kind_d != wd_kind_q);
    wd_clear     = (wd_kind_d == FC_NONE);
    wd_load_secs = (wd_kind_d == FC_FILL) ? 8'(FILL_LIMIT) : 8'(DRAIN_LIMIT);
  end

  // State, latched program, start history, fault code and watchdog kind.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      prog_q       <= PROG_QUICK;
      start_q      <= 1'b0;
      fault_code_q <= FC_NONE;
      wd_kind_q    <= FC_NONE;
    end else begin
      state_q      <= state_d;
      prog_q       <= prog_d;
      start_q      <= start;
      fault_code_q <= fault_code_d;
      wd_kind_q    <= wd_kind_d;
    end
  end

  sec_timer #(.TICK_DIV(TICK_DIV)) u_phase_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (ph_load),
    .clear     (ph_clear),
    .load_secs (ph_load_secs),
    .tick      (ph_tick_unused),
    .expired   (ph_expired),
    .secs      (ph_secs)
  );

  sec_timer #(.TICK_DIV(TICK_DIV)) u_watchdog (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (wd_load),
    .clear     (wd_clear),
    .load_secs (wd_load_secs),
    .tick      (wd_tick),
    .expired   (wd_expired_unused),
    .secs      (wd_secs)
  );

  assign start_out     = run_q;
  assign busy          = run_q;
  assign fault         = (state_q == ST_FAULT);
  assign fault_code    = fault_code_q;
  assign cycle_timeout = (state_q == ST_RUN_WASH) && ph_expired;
  assign spin_timeout  = (state_q == ST_RUN_SPIN) && ph_expired;
  assign secs_left     = (state_q inside {ST_RUN_WASH, ST_RUN_SPIN}) ? ph_secs : 8'd0;

endmodule

// File: doc/wash_program_sequencer.md
# wash_program_sequencer

Program controller that drives the automatic_washing_machine FSM. It gates the user start into the washer and times the wash and spin phases per selected program, generating `cycle_timeout` and `spin_timeout` itself. It runs fill/drain watchdogs and door supervision, and raises a sticky fault. It sits between the front panel inputs and the washer FSM, consuming the washer's status outputs.

## Interface
- `TICK_DIV`, 100: clock cycles per program second (prescaler).
- `FILL_LIMIT`, 30: max seconds `fill_value_on` may stay high.
- `DRAIN_LIMIT`, 20: max seconds of drain without motor.
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `prog_sel`  in  2  program: 0 quick, 1 normal, 2 heavy, 3 treated as normal.
- `start`  in  1  user start level.
- `door_close`  in  1  door switch.
- `motor_on`, `fill_value_on`, `drain_value_on`, `soap_wash`, `water_wash`, `done`  in  1 each  washer status.
- `start_out`  out  1  start to washer.
- `cycle_timeout`  out  1  wash/rinse phase expired.
- `spin_timeout`  out  1  spin phase expired.
- `busy`  out  1  program running.
- `fault`  out  1  sticky fault.
- `fault_code`  out  2  1 fill watchdog, 2 drain watchdog, 3 door opened.
- `secs_left`  out  8  remaining seconds of the current timed phase, 0 otherwise.

## Operation
- States: IDLE, RUN_FILL, RUN_WASH, RUN_DRAIN, RUN_SPIN, FAULT.
- Phase decode from status, registered once:
  - wash = `motor_on & ~drain_value_on`
  - spin = `motor_on & drain_value_on`
  - fill = `fill_value_on`
  - drain = `drain_value_on & ~motor_on`
- IDLE: a rising edge of `start` with `door_close=1` latches `prog_sel` and goes to RUN_FILL. `start` held high from a previous program does not restart.
- RUN_* states follow the decoded phase. Each state asserts `start_out` and `busy`.
- Phase durations, in seconds (wash / rinse / spin):
  - quick: 5 / 3 / 2
  - normal: 10 / 5 / 4
  - heavy: 20 / 8 / 6
- In RUN_WASH, the wash duration is used when `soap_wash=1`, and the rinse duration when `water_wash=1`.
- `cycle_timeout` and `spin_timeout` are levels. They are held until the decoded phase ends, then cleared the next cycle.
- `done=1` in any RUN state returns to IDLE. `start_out`, `busy` and the timeouts clear.
- Watchdogs:
  - fill condition continuous for `FILL_LIMIT` s → FAULT, code 1.
  - drain condition continuous for `DRAIN_LIMIT` s → FAULT, code 2.
- `door_close=0` while `busy` → FAULT, code 3, next edge, with priority over all else.
- FAULT: `start_out`, `busy` and the timeouts are 0; `fault=1`. It exits to IDLE only when `start=0` and `door_close=1` are sampled together, which clears `fault` and `fault_code`.
- Reset values: all outputs 0; state IDLE; counters 0. Reset mid-program aborts immediately.

## Timing
- `start_out` rises 1 cycle after the `start` rising edge is sampled.
- The phase timer and prescaler restart on the cycle the state enters a timed phase.
- For a timed phase of D seconds: the timeout rises exactly D·`TICK_DIV` cycles after the first edge sampling that phase.
- `secs_left` loads D on phase entry and decrements on each tick.
- If a phase ends before expiry, the timer clears and no timeout pulse is produced.
- Watchdog counters reset whenever their condition drops for one cycle.
- Simultaneous events, in priority order: door fault, then watchdog fault, then `done`, then phase change.

## Structure
- Package `wash_pkg`:
  - state enum
  - program enum
  - fault code constants
  - duration table (program × phase → seconds)
- Sub-module `sec_timer`: prescaler plus 8-bit down-counter, with load/clear inputs and `expired` and `tick` outputs. One instance is used for the phase timer and one for the watchdog.

## Test plan
Use `TICK_DIV`=4 for all scenarios.
- Quick program: `prog_sel`=0, `start` edge, door closed, washer in soap wash → `cycle_timeout` high 20 cycles after wash decode; spin → `spin_timeout` after 8 cycles.
- Heavy rinse: `water_wash`=1 in wash → `cycle_timeout` after 32 cycles; `secs_left` counts 8→0.
- `fill_value_on` stuck high with `FILL_LIMIT`=3 → `fault`=1, code 1 after 12 cycles; `start_out`=0. Then `start`=0 with door closed → IDLE, `fault`=0.
- Door opens mid-wash → `fault_code`=3 next edge; timeouts low. A watchdog expiring on the same cycle still reports code 3.
- `done` mid-spin, with `start` held high → IDLE; no restart until `start` falls and rises again.
- `reset_n` pulsed low mid-wash → all outputs 0 asynchronously; `prog_sel` change during a run is ignored.
